// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the program-counter unit.
//   pc_src_e : next-PC select encoding carried on pc_unit.pc_src
//   state_e  : fetch FSM states
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,   // pc + IALIGN
        PC_TARGET = 2'b01,   // branch/jump target (trapped if misaligned)
        PC_TRAP   = 2'b10,   // trap vector
        PC_HOLD   = 2'b11    // keep current pc
    } pc_src_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_e;

endpackage

// File: rtl/pc_unit_instret_counter.sv
// instret_counter: retired-instruction counter.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : add one this cycle
//   count : current count, wraps modulo 2^CNT_W
module instret_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with a two-state fetch FSM and retire counter.
//   clk, reset   : clock, synchronous active-high reset
//   pc_write     : update pc this cycle (honoured only in IDLE)
//   pc_src       : 00 seq, 01 target, 10 trap vector, 11 hold
//   target       : branch/jump target
//   fetch_start  : begin a fetch at the (possibly just updated) pc
//   mem_ready    : memory returned the fetched word
//   retire       : one instruction retires this cycle
//   mem_req      : high for the whole FETCH state
//   mem_addr     : fetch address, always equal to pc
//   fetch_done   : one-cycle pulse after the completing FETCH cycle
//   pc, old_pc   : current pc, pc of the most recently fetched instruction
//   misaligned   : one-cycle pulse when a misaligned target was trapped
//   instret      : retired-instruction count
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned      IALIGN       = 4,
    parameter int unsigned      CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic [1:0]       pc_src,
    input  logic [XLEN-1:0]  target,
    input  logic             fetch_start,
    input  logic             mem_ready,
    input  logic             retire,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    output logic             fetch_done,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  old_pc,
    output logic             misaligned,
    output logic [CNT_W-1:0] instret
);

    // IALIGN is a power of two, so "target mod IALIGN" is a low-bit mask.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    state_e          state;
    logic [XLEN-1:0] next_pc;
    logic            target_bad;

    assign mem_addr = pc;

    // Candidate pc for a write in IDLE; arithmetic wraps naturally at XLEN bits.
    always_comb begin
        next_pc    = pc;
        target_bad = 1'b0;
        case (pc_src_e'(pc_src))
            PC_SEQ:    next_pc = pc + XLEN'(IALIGN);
            PC_TARGET: begin
                target_bad = (target & ALIGN_MASK) != '0;
                next_pc    = target_bad ? TRAP_VECTOR : target;
            end
            PC_TRAP:   next_pc = TRAP_VECTOR;
            PC_HOLD:   next_pc = pc;
            default:   next_pc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_VECTOR;
            old_pc     <= RESET_VECTOR;
            mem_req    <= 1'b0;
            fetch_done <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    // pc update and fetch entry share the edge, so the
                    // fetch presents the freshly written pc on mem_addr.
                    if (pc_write) begin
                        pc         <= next_pc;
                        misaligned <= target_bad;
                    end
                    if (fetch_start) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // pc_write and fetch_start are ignored here: pc is frozen.
                    if (mem_ready) begin
                        state      <= S_IDLE;
                        mem_req    <= 1'b0;
                        fetch_done <= 1'b1;
                        old_pc     <= pc;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (instret)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: two instances (IALIGN=4/CNT_W=64 and
// IALIGN=2/CNT_W=4) share stimulus; a reference model pushes expected
// outputs and a monitor pops and compares one entry per clock.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0, pc_write = 1'b0, fetch_start = 1'b0;
    logic        mem_ready = 1'b0, retire = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] target = '0;

    logic        mem_req0, fetch_done0, misaligned0;
    logic [31:0] mem_addr0, pc0, old_pc0;
    logic [63:0] instret0;
    logic        mem_req1, fetch_done1, misaligned1;
    logic [31:0] mem_addr1, pc1, old_pc1;
    logic [3:0]  instret1;

    always #5 clk = ~clk;

    pc_unit u0 (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_src(pc_src),
        .target(target), .fetch_start(fetch_start), .mem_ready(mem_ready),
        .retire(retire), .mem_req(mem_req0), .mem_addr(mem_addr0),
        .fetch_done(fetch_done0), .pc(pc0), .old_pc(old_pc0),
        .misaligned(misaligned0), .instret(instret0)
    );

    pc_unit #(.IALIGN(2), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_src(pc_src),
        .target(target), .fetch_start(fetch_start), .mem_ready(mem_ready),
        .retire(retire), .mem_req(mem_req1), .mem_addr(mem_addr1),
        .fetch_done(fetch_done1), .pc(pc1), .old_pc(old_pc1),
        .misaligned(misaligned1), .instret(instret1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        fetching;
        logic [31:0] pc;
        logic [31:0] old;
        logic [63:0] cnt;
        logic        fd;
        logic        mis;
    } mstate_t;

    typedef struct packed {
        mstate_t a;
        mstate_t b;
    } exp_t;

    mstate_t m0, m1;
    exp_t    sb[$];
    int      passed = 0;
    int      total  = 0;

    function automatic mstate_t step(mstate_t s, logic r, logic pw, logic [1:0] src,
                                     logic [31:0] tgt, logic fs, logic mr, logic ret,
                                     int unsigned ialign, logic [63:0] mask);
        mstate_t n = s;
        longint unsigned sum;
        if (r) begin
            n = '0;
            return n;
        end
        n.fd  = 1'b0;
        n.mis = 1'b0;
        if (ret) n.cnt = (s.cnt + 64'd1) & mask;
        if (s.fetching) begin
            if (mr) begin
                n.fetching = 1'b0;
                n.fd       = 1'b1;
                n.old      = s.pc;
            end
        end else begin
            if (pw) begin
                if (src == 2'd0) begin
                    sum  = (longint'(s.pc) + longint'(ialign)) % 64'h1_0000_0000;
                    n.pc = sum[31:0];
                end else if (src == 2'd1) begin
                    if (tgt % ialign != 0) begin
                        n.pc  = 32'h100;
                        n.mis = 1'b1;
                    end else begin
                        n.pc = tgt;
                    end
                end else if (src == 2'd2) begin
                    n.pc = 32'h100;
                end
            end
            if (fs) n.fetching = 1'b1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs at the falling edge and record the model's prediction.
    task automatic cyc(input logic r, input logic pw, input logic [1:0] src,
                       input logic [31:0] tgt, input logic fs, input logic mr, input logic ret);
        exp_t e;
        @(negedge clk);
        reset = r; pc_write = pw; pc_src = src; target = tgt;
        fetch_start = fs; mem_ready = mr; retire = ret;
        m0 = step(m0, r, pw, src, tgt, fs, mr, ret, 4, 64'hFFFF_FFFF_FFFF_FFFF);
        m1 = step(m1, r, pw, src, tgt, fs, mr, ret, 2, 64'h0000_0000_0000_000F);
        e.a = m0;
        e.b = m1;
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("u0.mem_req",    64'(mem_req0),    64'(e.a.fetching));
                check("u0.mem_addr",   64'(mem_addr0),   64'(e.a.pc));
                check("u0.pc",         64'(pc0),         64'(e.a.pc));
                check("u0.old_pc",     64'(old_pc0),     64'(e.a.old));
                check("u0.fetch_done", 64'(fetch_done0), 64'(e.a.fd));
                check("u0.misaligned", 64'(misaligned0), 64'(e.a.mis));
                check("u0.instret",    instret0,         e.a.cnt);
                check("u1.mem_req",    64'(mem_req1),    64'(e.b.fetching));
                check("u1.mem_addr",   64'(mem_addr1),   64'(e.b.pc));
                check("u1.pc",         64'(pc1),         64'(e.b.pc));
                check("u1.old_pc",     64'(old_pc1),     64'(e.b.old));
                check("u1.fetch_done", 64'(fetch_done1), 64'(e.b.fd));
                check("u1.misaligned", 64'(misaligned1), 64'(e.b.mis));
                check("u1.instret",    64'(instret1),    e.b.cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] t;
        int          waited;
        m0 = '0;
        m1 = '0;

        // Reset held for two cycles.
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("reset.pc", 64'(pc0), 64'h0);
        check("reset.instret", instret0, 64'h0);
        check("reset.mem_req", 64'(mem_req0), 64'h0);
        idle();

        // Fetch with mem_ready on the third FETCH cycle.
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        settle();
        check("fetch.mem_req", 64'(mem_req0), 64'h1);
        check("fetch.mem_addr", 64'(mem_addr0), 64'h0);
        idle();
        idle();
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        settle();
        check("fetch.done", 64'(fetch_done0), 64'h1);
        check("fetch.old_pc", 64'(old_pc0), 64'h0);
        check("fetch.req_low", 64'(mem_req0), 64'h0);
        idle();
        settle();
        check("fetch.done_pulse", 64'(fetch_done0), 64'h0);

        // Sequential then jump.
        cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("seq.pc", 64'(pc0), 64'h4);
        cyc(1'b0, 1'b1, 2'd1, 32'h80, 1'b0, 1'b0, 1'b0);
        settle();
        check("jump.pc", 64'(pc0), 64'h80);

        // Misaligned target: trapped at IALIGN=4, legal at IALIGN=2.
        cyc(1'b0, 1'b1, 2'd1, 32'h82, 1'b0, 1'b0, 1'b0);
        settle();
        check("mis4.pc", 64'(pc0), 64'h100);
        check("mis4.pulse", 64'(misaligned0), 64'h1);
        check("mis2.pc", 64'(pc1), 64'h82);
        check("mis2.pulse", 64'(misaligned1), 64'h0);
        idle();
        settle();
        check("mis4.pulse_end", 64'(misaligned0), 64'h0);

        // pc frozen during FETCH; write+start in IDLE fetches the new pc.
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 32'h40, 1'b0, 1'b0, 1'b0);
        settle();
        check("stable.pc", 64'(pc0), 64'h100);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 32'h40, 1'b1, 1'b0, 1'b0);
        settle();
        check("wstart.mem_addr", 64'(mem_addr0), 64'h40);
        check("wstart.mem_req", 64'(mem_req0), 64'h1);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        settle();
        check("fs_in_fetch.idle", 64'(mem_req0), 64'h0);

        // PC wrap at top of address space.
        cyc(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("wrap.pc", 64'(pc0), 64'h0);

        // Counter wrap on the 4-bit instance: 15 retires -> all ones, one more -> 0.
        for (int unsigned i = 0; i < 15; i++)
            cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        settle();
        check("cnt.all_ones", 64'(instret1), 64'hF);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        settle();
        check("cnt.wrap", 64'(instret1), 64'h0);
        check("cnt.wide", instret0, 64'd16);

        // Reset mid-fetch abandons the request without fetch_done.
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1);
        settle();
        check("midreset.mem_req", 64'(mem_req0), 64'h0);
        check("midreset.done", 64'(fetch_done0), 64'h0);
        check("midreset.instret", instret0, 64'h0);

        // Randomized traffic, model-checked by the monitor.
        for (int unsigned i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: t = $urandom;
                1: t = $urandom & 32'hFFFF_FFFC;
                2: t = 32'hFFFF_FFF0 | ($urandom & 32'hE);
                default: t = $urandom & 32'h0000_01FF;
            endcase
            cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                t,
                ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)));
        end
        idle();

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            #3;
            waited++;
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain actual=%0d entries left required=0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC, target and address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: redirect address on a misaligned target.
REQ-004 SHALL have parameter IALIGN, default 4: instruction alignment in bytes; legal values 2 and 4 only.
REQ-005 SHALL have parameter CNT_W, default 64: retired-instruction counter width.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port pc_write  input  1  request a PC update this cycle.
REQ-009 SHALL have port pc_src  input  2  next-PC select: 00 sequential, 01 target, 10 trap vector, 11 hold.
REQ-010 SHALL have port target  input  XLEN  branch/jump target address.
REQ-011 SHALL have port fetch_start  input  1  begin an instruction fetch at the current PC.
REQ-012 SHALL have port mem_ready  input  1  memory has returned the fetched word.
REQ-013 SHALL have port retire  input  1  one instruction retires this cycle.
REQ-014 SHALL have port mem_req  output  1  fetch request, high for the whole FETCH state.
REQ-015 SHALL have port mem_addr  output  XLEN  fetch address; always equals pc.
REQ-016 SHALL have port fetch_done  output  1  one-cycle pulse when a fetch completes.
REQ-017 SHALL have port pc  output  XLEN  current program counter (registered).
REQ-018 SHALL have port old_pc  output  XLEN  PC of the most recently fetched instruction.
REQ-019 SHALL have port misaligned  output  1  one-cycle pulse on a trapped misaligned target.
REQ-020 SHALL have port instret  output  CNT_W  retired-instruction count.

Function
REQ-021 SHALL implement a two-state FSM, IDLE and FETCH: IDLE goes to FETCH on fetch_start; FETCH goes to IDLE on mem_ready.
REQ-022 SHALL drive mem_req high exactly while the FSM is in FETCH; fetch latency is one cycle minimum and unbounded while mem_ready is low.
REQ-023 SHALL, on the FETCH cycle with mem_ready high, register fetch_done=1 for the next cycle only and load old_pc with pc.
REQ-024 SHALL apply pc_write only in IDLE; pc_write in FETCH is ignored and pc stays stable.
REQ-025 SHALL load pc on pc_write in IDLE with: 00 -> pc+IALIGN; 01 -> target; 10 -> TRAP_VECTOR; 11 -> pc unchanged.
REQ-026 SHALL compute all PC arithmetic modulo 2^XLEN, so pc+IALIGN wraps to 0 at the top of the address space.
REQ-027 SHALL, when pc_src=01 and target mod IALIGN is nonzero, load TRAP_VECTOR instead of target and pulse misaligned for one cycle.
REQ-028 SHALL, on pc_write and fetch_start together in IDLE, update pc and enter FETCH so the fetch uses the new pc.
REQ-029 SHALL increment instret by 1 on every retire cycle, in any FSM state, and wrap from 2^CNT_W-1 to 0.
REQ-030 SHALL ignore fetch_start while in FETCH; a FETCH cycle with both mem_ready and fetch_start returns to IDLE.

Reset
REQ-031 SHALL, when reset is high at a clock edge, set pc=RESET_VECTOR, old_pc=RESET_VECTOR, instret=0, FSM=IDLE, mem_req=0, fetch_done=0 and misaligned=0.
REQ-032 SHALL let reset take priority over every other input, including mid-fetch, abandoning any outstanding request with no fetch_done.

Structure
REQ-033 SHALL place the pc_src encoding constants and the FSM state type in shared package pc_pkg.
REQ-034 SHALL implement the retire counter as sub-module instret_counter, parameterised by CNT_W, with ports clk, reset, inc and count.

Verification
REQ-035 SHALL cover reset: assert reset for 2 cycles -> pc=0x0, instret=0, mem_req=0.
REQ-036 SHALL cover a fetch: fetch_start in IDLE, mem_ready after 3 cycles -> mem_req high for 3 cycles, mem_addr=0x0, fetch_done for 1 cycle, old_pc=0x0.
REQ-037 SHALL cover sequential and jump updates: pc_write with pc_src=00 from 0x0 -> pc=0x4; then pc_src=01 with target=0x80 -> pc=0x80.
REQ-038 SHALL cover a misaligned target: pc_src=01 with target=0x82 and IALIGN=4 -> pc=0x100 and misaligned pulse; the same stimulus with IALIGN=2 -> pc=0x82 and no pulse.
REQ-039 SHALL cover a stable PC during fetch: pc_write during FETCH -> pc unchanged; pc_write with fetch_start in IDLE -> mem_addr shows the new pc.
REQ-040 SHALL cover wrap-around: pc=0xFFFF_FFFC with pc_src=00 -> pc=0x0; instret preloaded to all ones, then retire -> instret=0.
